// File: rtl/sme_multi.sv
// String-matching engine: stores a string and a pattern, then scans one start
// position per cycle with '^'/'$' anchors, '.' wildcard and optional nocase.
module sme_multi #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  input  logic             nocase,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic [IDX_W:0]   match_count
);

  localparam int LEN_W = IDX_W + 1;
  localparam int PL_W  = $clog2(PAT_MAX + 1);
  localparam int PI_W  = $clog2(PAT_MAX);

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       str_q [STR_MAX];
  logic [7:0]       pat_q [PAT_MAX];
  logic [LEN_W-1:0] len_q, len_d;
  logic [PL_W-1:0]  plen_q, plen_d;
  logic             nocase_q, nocase_d;
  logic [LEN_W-1:0] s_q, s_d;
  logic             found_q, found_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             match_q;
  logic [IDX_W-1:0] index_q;
  logic [LEN_W-1:0] count_q;

  logic             str_rise, pat_rise, str_we, pat_we, eval_en, hit, head, tail;
  logic [LEN_W-1:0] s_cur, str_base;
  logic [PL_W-1:0]  pat_base;
  int               body_len, s_int, l_int, e_int, p_int;

  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= "A" && c <= "Z") ? (c | 8'h20) : c;
  endfunction

  function automatic logic char_eq(input logic [7:0] a, input logic [7:0] b, input logic nc);
    return nc ? (fold(a) == fold(b)) : (a == b);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk) begin : state_reg
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output is defaulted first so no path infers a latch.
  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE, LOAD_STR: begin
        if (isstring)       state_d = LOAD_STR;
        else if (ispattern) state_d = LOAD_PAT;
        else                state_d = IDLE;
      end
      // The first cycle with ispattern low already evaluates start position 0.
      LOAD_PAT: begin
        if (ispattern) state_d = isstring ? LOAD_STR : LOAD_PAT;
        else           state_d = (len_q == '0) ? DONE : SEARCH;
      end
      SEARCH:  if (s_q == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    valid       = (state_q == DONE);
    match       = match_q;
    match_index = index_q;
    match_count = count_q;
  end

  always_comb begin : load_ctrl
    str_rise = (state_d == LOAD_STR) && (state_q != LOAD_STR);
    pat_rise = (state_d == LOAD_PAT) && (state_q != LOAD_PAT);
    str_base = str_rise ? '0 : len_q;
    pat_base = pat_rise ? '0 : plen_q;
    str_we   = (state_d == LOAD_STR) && (int'(str_base) < STR_MAX);
    pat_we   = (state_d == LOAD_PAT) && (int'(pat_base) < PAT_MAX);
    len_d    = str_we ? str_base + 1'b1 : len_q;
    plen_d   = pat_we ? pat_base + 1'b1 : plen_q;
    nocase_d = pat_rise ? nocase : nocase_q;
  end

  // Anchors are peeled off the stored pattern; the remaining body is compared
  // against the string at s_cur in parallel.
  always_comb begin : matcher
    eval_en  = (state_q == SEARCH) || (state_q == LOAD_PAT && !ispattern);
    s_cur    = (state_q == SEARCH) ? s_q : '0;
    head     = (plen_q != '0) && (pat_q[0] == 8'h5E);
    tail     = 1'b0;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (int'(plen_q) == k + 1 && pat_q[k] == 8'h24 && !(head && k == 0)) tail = 1'b1;
    end
    body_len = int'(plen_q) - int'(head) - int'(tail);
    s_int    = int'(s_cur);
    l_int    = int'(len_q);
    e_int    = s_int + body_len;
    p_int    = 0;
    hit      = (e_int <= l_int);
    if (head && s_int != 0 && str_q[IDX_W'(s_int - 1)] != 8'h20) hit = 1'b0;
    if (tail && e_int < l_int && str_q[IDX_W'(e_int)] != 8'h20)  hit = 1'b0;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (k >= int'(head) && k < int'(head) + body_len) begin
        p_int = s_int + k - int'(head);
        if (p_int < l_int && pat_q[k] != 8'h2E &&
            !char_eq(pat_q[k], str_q[IDX_W'(p_int)], nocase_q)) hit = 1'b0;
      end
    end
  end

  always_comb begin : accumulate
    found_d = (state_q == SEARCH) ? found_q : 1'b0;
    first_d = (state_q == SEARCH) ? first_q : '0;
    cnt_d   = (state_q == SEARCH) ? cnt_q   : '0;
    s_d     = s_q;
    if (eval_en) begin
      s_d = s_cur + 1'b1;
      if (hit && len_q != '0) begin
        if (!found_d) first_d = IDX_W'(s_cur);
        found_d = 1'b1;
        cnt_d   = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin : datapath_reg
    if (reset) begin
      len_q    <= '0;
      plen_q   <= '0;
      nocase_q <= 1'b0;
      s_q      <= '0;
      found_q  <= 1'b0;
      first_q  <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      index_q  <= '0;
      count_q  <= '0;
    end else begin
      len_q    <= len_d;
      plen_q   <= plen_d;
      nocase_q <= nocase_d;
      s_q      <= s_d;
      found_q  <= found_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      if (state_d == DONE && state_q != DONE) begin
        match_q <= found_d;
        index_q <= first_d;
        count_q <= cnt_d;
      end
    end
  end

  // NOTE: the character arrays are not reset; len_q and plen_q gate every read.
  always_ff @(posedge clk) begin : storage
    if (str_we) str_q[IDX_W'(str_base)] <= chardata;
    if (pat_we) pat_q[PI_W'(pat_base)]  <= chardata;
  end

endmodule

// File: tb/tb_sme_multi.sv
// Scoreboard bench for sme_multi: directed strings/patterns push expected
// results; a negedge monitor pops and compares on every valid strobe.
module tb_sme_multi;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = $clog2(STR_MAX);

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       chardata;
  logic             isstring, ispattern, nocase;
  logic             valid, match;
  logic [IDX_W-1:0] match_index;
  logic [IDX_W:0]   match_count;

  sme_multi #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .nocase(nocase), .valid(valid), .match(match),
    .match_index(match_index), .match_count(match_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    bit    m;
    int    idx;
    int    cnt;
    int    at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   nvalid = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && valid === 1'b1) begin
      nvalid++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d, no result expected", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, ".match"}, int'(match), int'(e.m));
        check({e.name, ".index"}, int'(match_index), e.idx);
        check({e.name, ".count"}, int'(match_count), e.cnt);
        check({e.name, ".cycle"}, cyc, e.at);
      end
    end
  end

  task automatic idle_inputs();
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    nocase    = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input bit s, input bit p, input bit nc);
    chardata  = c;
    isstring  = s;
    ispattern = p;
    nocase    = nc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout with %0d results outstanding", name, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1, 1'b0, 1'b0);
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  // l is the stored string length, so valid is due l+1 cycles after the last char.
  task automatic run_pat(input string pat, input bit nc, input int l,
                         input bit m, input int idx, input int cnt, input bit push);
    exp_t e;
    for (int i = 0; i < pat.len(); i++) send_char(pat[i], 1'b0, 1'b1, nc);
    idle_inputs();
    if (push) begin
      e.name = $sformatf("%s/nc%0d/L%0d", pat, nc, l);
      e.m    = m;
      e.idx  = idx;
      e.cnt  = cnt;
      e.at   = cyc + l + 1;
      sb.push_back(e);
      wait_idle(e.name);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int v0;
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid", int'(valid), 0);
    check("reset.match", int'(match), 0);
    check("reset.index", int'(match_index), 0);
    check("reset.count", int'(match_count), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    load_str("hello world");
    run_pat("o",     1'b0, 11, 1'b1, 4, 2,  1'b1);
    run_pat("^wor",  1'b0, 11, 1'b1, 6, 1,  1'b1);
    run_pat("ld$",   1'b0, 11, 1'b1, 9, 1,  1'b1);
    run_pat("l.o",   1'b0, 11, 1'b1, 2, 1,  1'b1);
    run_pat("^o",    1'b0, 11, 1'b0, 0, 0,  1'b1);
    run_pat(".",     1'b0, 11, 1'b1, 0, 11, 1'b1);
    run_pat("HELLO", 1'b1, 11, 1'b1, 0, 1,  1'b1);
    run_pat("HELLO", 1'b0, 11, 1'b0, 0, 0,  1'b1);
    // Only "hello wo" survives truncation to PAT_MAX characters.
    run_pat("hello woXY", 1'b0, 11, 1'b1, 0, 1, 1'b1);

    // First string char arrives with ispattern also high: it must load as string.
    send_char("a", 1'b1, 1'b1, 1'b0);
    load_str("bc");
    run_pat("abc", 1'b0, 3, 1'b1, 0, 1, 1'b1);
    run_pat("bc",  1'b0, 3, 1'b1, 1, 1, 1'b1);

    // 40 characters a..z,a..n; only the first 32 are kept.
    for (int i = 0; i < 40; i++) send_char(8'(97 + i % 26), 1'b1, 1'b0, 1'b0);
    idle_inputs();
    @(posedge clk);
    #1;
    run_pat("$",  1'b0, 32, 1'b1, 0, 1, 1'b1);
    run_pat("^",  1'b0, 32, 1'b1, 0, 1, 1'b1);
    run_pat("^$", 1'b0, 32, 1'b0, 0, 0, 1'b1);
    run_pat("ab", 1'b0, 32, 1'b1, 0, 2, 1'b1);

    // Reset lands on search cycle 5 of a 32-cycle scan.
    run_pat("ab", 1'b0, 32, 1'b0, 0, 0, 1'b0);
    v0 = nvalid;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort.valid", int'(valid), 0);
    check("abort.match", int'(match), 0);
    check("abort.index", int'(match_index), 0);
    check("abort.count", int'(match_count), 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort.no_valid", nvalid - v0, 0);
    run_pat("ab", 1'b0, 0, 1'b0, 0, 0, 1'b1);

    wait_idle("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
